// File: rtl/multi_core_obi_arbiter.sv
// Round-robin arbiter that merges NUM_CORES OBI requestors onto one downstream OBI port.
// Responses are routed back in order through a small FIFO of granted core indices.
module multi_core_obi_arbiter #(
    parameter  int NUM_CORES       = 2,
    parameter  int ADDR_W          = 32,
    parameter  int DATA_W          = 32,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int BE_W            = DATA_W / 8,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_CORES-1:0]        s_req_i,
    output logic [NUM_CORES-1:0]        s_gnt_o,
    input  logic [NUM_CORES-1:0]        s_we_i,
    input  logic [NUM_CORES*BE_W-1:0]   s_be_i,
    input  logic [NUM_CORES*ADDR_W-1:0] s_addr_i,
    input  logic [NUM_CORES*DATA_W-1:0] s_wdata_i,
    output logic [NUM_CORES-1:0]        s_rvalid_o,
    output logic [DATA_W-1:0]           s_rdata_o,
    output logic                        m_req_o,
    input  logic                        m_gnt_i,
    output logic                        m_we_o,
    output logic [BE_W-1:0]             m_be_o,
    output logic [ADDR_W-1:0]           m_addr_o,
    output logic [DATA_W-1:0]           m_wdata_o,
    input  logic                        m_rvalid_i,
    input  logic [DATA_W-1:0]           m_rdata_i,
    output logic                        err_o,
    output logic [CNT_W-1:0]            outstanding_o
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDX_W-1:0]  rr_ptr_reg;
    logic              lock_valid_reg;
    logic [IDX_W-1:0]  lock_idx_reg;
    logic [IDX_W-1:0]  fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              err_reg;

    logic [ADDR_W-1:0] core_addr  [NUM_CORES];
    logic [DATA_W-1:0] core_wdata [NUM_CORES];
    logic [BE_W-1:0]   core_be    [NUM_CORES];
    logic [NUM_CORES-1:0] above_ptr;
    logic [NUM_CORES-1:0] masked_req;

    logic [IDX_W-1:0]  rr_pick;
    logic              rr_found;
    logic [IDX_W-1:0]  low_pick;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  winner_next;
    logic [IDX_W-1:0]  head_idx;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic              any_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              handshake;
    logic              pop;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign core_addr[gi]  = s_addr_i[gi*ADDR_W +: ADDR_W];
            assign core_wdata[gi] = s_wdata_i[gi*DATA_W +: DATA_W];
            assign core_be[gi]    = s_be_i[gi*BE_W +: BE_W];
            assign above_ptr[gi]  = (gi >= int'(rr_ptr_reg));
            assign s_gnt_o[gi]    = handshake && (winner == IDX_W'(gi));
            assign s_rvalid_o[gi] = pop && (head_idx == IDX_W'(gi));
        end
    endgenerate

    // Two-pass search: first the requestors at or above rr_ptr, then wrap to the lowest index.
    assign masked_req = s_req_i & above_ptr;
    always_comb begin
        rr_pick  = '0;
        rr_found = 1'b0;
        low_pick = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (masked_req[i]) begin
                rr_pick  = IDX_W'(i);
                rr_found = 1'b1;
            end
            if (s_req_i[i]) begin
                low_pick = IDX_W'(i);
            end
        end
    end

    assign winner      = lock_valid_reg ? lock_idx_reg : (rr_found ? rr_pick : low_pick);
    assign winner_next = (winner == IDX_W'(NUM_CORES - 1)) ? '0 : winner + IDX_W'(1);

    assign any_req    = |s_req_i;
    assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_reg == '0);

    // Reset gating keeps every handshake output quiet while rst_ni is low.
    assign m_req_o   = rst_ni && any_req && !fifo_full;
    assign handshake = m_req_o && m_gnt_i;
    assign pop       = rst_ni && m_rvalid_i && !fifo_empty;
    assign head_idx  = fifo_mem[rd_ptr_reg];

    assign m_we_o    = m_req_o ? s_we_i[winner]     : 1'b0;
    assign m_be_o    = m_req_o ? core_be[winner]    : '0;
    assign m_addr_o  = m_req_o ? core_addr[winner]  : '0;
    assign m_wdata_o = m_req_o ? core_wdata[winner] : '0;

    assign s_rdata_o     = m_rdata_i;
    assign err_o         = err_reg;
    assign outstanding_o = count_reg;

    assign wr_ptr_next = (wr_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
    assign rd_ptr_next = (rd_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_reg     <= '0;
            lock_valid_reg <= 1'b0;
            lock_idx_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            if (handshake) begin
                lock_valid_reg <= 1'b0;
                rr_ptr_reg     <= winner_next;
                wr_ptr_reg     <= wr_ptr_next;
            end else if (m_req_o) begin
                lock_valid_reg <= 1'b1;
                lock_idx_reg   <= winner;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            case ({handshake, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (m_rvalid_i && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_mem[wr_ptr_reg] <= winner;
        end
    end

endmodule
